// File: rtl/loader_pkg.sv
// loader_pkg: shared widths, state encoding and default padding opcode for the computer_4bit loader
package loader_pkg;
  localparam int ADDR_W = 4;
  localparam int INS_W  = 8;
  localparam int DATA_W = 4;
  localparam int WC_W   = 5;
  localparam int CNT_W  = 8;
  localparam logic [INS_W-1:0] HLT_DEFAULT = 8'h0F;
  typedef enum logic [2:0] {IDLE, LOAD, PAD, RELEASE, RUN, DONE} state_e;
endpackage

// File: rtl/computer_4bit_cycle_cnt.sv
// computer_4bit_cycle_cnt: free-running up-counter with synchronous clear
module computer_4bit_cycle_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  output logic [W-1:0] count_o
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = clr_i ? '0 : count_q + 1'b1;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= '0;
    else      count_q <= count_d;
  assign count_o = count_q;
endmodule

// File: rtl/computer_4bit_loader.sv
// computer_4bit_loader: streams host words into computer_4bit, pads with HLT, runs it and captures the result
module computer_4bit_loader
  import loader_pkg::*;
#(
  parameter int               RUN_CYCLES = 32,
  parameter bit               PAD_HLT    = 1'b1,
  parameter logic [INS_W-1:0] HLT_OPCODE = HLT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [INS_W-1:0]  host_ins,
  input  logic [DATA_W-1:0] host_data,
  input  logic              host_last,
  output logic              cpu_rst,
  output logic [INS_W-1:0]  cpu_ins,
  output logic [DATA_W-1:0] cpu_d_in,
  output logic [ADDR_W-1:0] cpu_ins_address,
  input  logic [DATA_W-1:0] cpu_d_out,
  input  logic              cpu_zf,
  input  logic              cpu_cf,
  output logic              busy,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_d,
  output logic              result_zf,
  output logic              result_cf,
  output logic [WC_W-1:0]   word_count
);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, cpu_addr_q, cpu_addr_d;
  logic [INS_W-1:0]  cpu_ins_q, cpu_ins_d;
  logic [DATA_W-1:0] cpu_d_in_q, cpu_d_in_d, res_d_q, res_d_d;
  logic [WC_W-1:0]   word_count_q, word_count_d;
  logic              cpu_rst_q, cpu_rst_d, res_zf_q, res_zf_d, res_cf_q, res_cf_d;
  logic [CNT_W-1:0]  run_cnt;
  logic              hs, addr_last, run_done, go;

  computer_4bit_cycle_cnt #(.W(CNT_W)) u_run_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q != RUN),
    .count_o (run_cnt)
  );

  assign hs        = host_valid & host_ready;
  assign addr_last = addr_q == '1;
  assign run_done  = run_cnt == CNT_W'(RUN_CYCLES - 1);
  assign go        = start & ~abort & (state_q == IDLE || state_q == DONE);

  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD:       if (hs && (host_last || addr_last)) state_d = (PAD_HLT && !addr_last) ? PAD : RELEASE;
      PAD:        if (addr_last) state_d = RELEASE;
      RELEASE:    state_d = RUN;
      RUN:        if (run_done) state_d = DONE;
      default:    state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_comb begin
    host_ready   = state_q == LOAD && !abort;
    busy         = state_q inside {LOAD, PAD, RELEASE, RUN};
    result_valid = state_q == DONE;
  end

  // Address saturates at 15 so the last slot is never followed by a wrap to 0
  always_comb begin
    addr_d       = addr_q;
    word_count_d = word_count_q;
    cpu_addr_d   = cpu_addr_q;
    cpu_ins_d    = cpu_ins_q;
    cpu_d_in_d   = cpu_d_in_q;
    res_d_d      = res_d_q;
    res_zf_d     = res_zf_q;
    res_cf_d     = res_cf_q;
    if (go) begin
      addr_d       = '0;
      word_count_d = '0;
    end
    if (hs) begin
      cpu_ins_d    = host_ins;
      cpu_d_in_d   = host_data;
      cpu_addr_d   = addr_q;
      word_count_d = word_count_q + 5'd1;
      addr_d       = addr_last ? addr_q : addr_q + 1'b1;
    end
    if (state_q == PAD && !abort) begin
      cpu_ins_d  = HLT_OPCODE;
      cpu_d_in_d = '0;
      cpu_addr_d = addr_q;
      addr_d     = addr_last ? addr_q : addr_q + 1'b1;
    end
    if (state_q == RUN && run_done && !abort) begin
      res_d_d  = cpu_d_out;
      res_zf_d = cpu_zf;
      res_cf_d = cpu_cf;
    end
    cpu_rst_d = state_d != RUN;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addr_q       <= '0;
      word_count_q <= '0;
      cpu_addr_q   <= '0;
      cpu_ins_q    <= '0;
      cpu_d_in_q   <= '0;
      cpu_rst_q    <= 1'b1;
      res_d_q      <= '0;
      res_zf_q     <= 1'b0;
      res_cf_q     <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      cpu_addr_q   <= cpu_addr_d;
      cpu_ins_q    <= cpu_ins_d;
      cpu_d_in_q   <= cpu_d_in_d;
      cpu_rst_q    <= cpu_rst_d;
      res_d_q      <= res_d_d;
      res_zf_q     <= res_zf_d;
      res_cf_q     <= res_cf_d;
    end

  assign cpu_rst         = cpu_rst_q;
  assign cpu_ins         = cpu_ins_q;
  assign cpu_d_in        = cpu_d_in_q;
  assign cpu_ins_address = cpu_addr_q;
  assign word_count      = word_count_q;
  assign result_d        = res_d_q;
  assign result_zf       = res_zf_q;
  assign result_cf       = res_cf_q;
endmodule

// File: tb/tb_computer_4bit_loader.sv
// tb_computer_4bit_loader: two loaders (PAD_HLT 0 and 1) on one host stream, checked against a write scoreboard and memory models
module tb_computer_4bit_loader;
  logic       clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0;
  logic       host_valid = 1'b0, host_last = 1'b0, mem_clr = 1'b1;
  logic [7:0] host_ins = '0;
  logic [3:0] host_data = '0;
  logic       host_ready [2], cpu_rst [2], busy [2], result_valid [2], result_zf [2], result_cf [2];
  logic [7:0] cpu_ins [2];
  logic [3:0] cpu_d_in [2], cpu_ins_address [2], result_d [2];
  logic [4:0] word_count [2];
  int         n_chk = 0, n_fail = 0, exp_addr = 0;
  logic [15:0] sb [$];
  logic [11:0] prog [6] = '{12'h160, 12'h028, 12'h170, 12'h0E0, 12'h040, 12'h0F0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [11:0] mem [16];
    int          low_cnt;
    computer_4bit_loader #(.RUN_CYCLES(5), .PAD_HLT(g == 1)) dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .abort           (abort),
      .host_valid      (host_valid),
      .host_ready      (host_ready[g]),
      .host_ins        (host_ins),
      .host_data       (host_data),
      .host_last       (host_last),
      .cpu_rst         (cpu_rst[g]),
      .cpu_ins         (cpu_ins[g]),
      .cpu_d_in        (cpu_d_in[g]),
      .cpu_ins_address (cpu_ins_address[g]),
      .cpu_d_out       (4'hA),
      .cpu_zf          (1'b1),
      .cpu_cf          (1'b0),
      .busy            (busy[g]),
      .result_valid    (result_valid[g]),
      .result_d        (result_d[g]),
      .result_zf       (result_zf[g]),
      .result_cf       (result_cf[g]),
      .word_count      (word_count[g])
    );
    // Behavioural program memory: the computer latches the load bus on every edge while held in reset
    always @(posedge clk)
      if (mem_clr) begin
        for (int k = 0; k < 16; k++) mem[k] <= 12'hFFF;
        low_cnt <= 0;
      end else begin
        if (cpu_rst[g] && busy[g]) mem[cpu_ins_address[g]] <= {cpu_ins[g], cpu_d_in[g]};
        if (!cpu_rst[g]) low_cnt <= low_cnt + 1;
      end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mem_clr = 1'b1;
    sb.delete();
    tick();
    tick();
    rst = 1'b1;
    mem_clr = 1'b0;
  endtask

  task automatic do_start();
    exp_addr = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input bit only1);
    logic [15:0] e;
    e = sb.pop_front();
    if (!only1) chk({tag, "_dut0"}, 32'({cpu_ins_address[0], cpu_ins[0], cpu_d_in[0]}), 32'(e));
    chk({tag, "_dut1"}, 32'({cpu_ins_address[1], cpu_ins[1], cpu_d_in[1]}), 32'(e));
  endtask

  task automatic send(input logic [7:0] ins, input logic [3:0] d, input logic last, output logic ok);
    host_valid = 1'b1;
    host_ins   = ins;
    host_data  = d;
    host_last  = last;
    ok = host_ready[0];
    if (ok) sb.push_back({4'(exp_addr), ins, d});
    tick();
    host_valid = 1'b0;
    host_last  = 1'b0;
    if (ok) begin
      exp_addr++;
      pop_chk("word", 1'b0);
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(result_valid[0] && result_valid[1]) && n < budget) begin
      tick();
      n++;
    end
    chk("done_in_budget", 32'(result_valid[0] & result_valid[1]), 32'd1);
  endtask

  initial begin
    logic ok;
    int   acc;
    tick();
    chk("rst_cpu_rst", 32'(cpu_rst[0]), 32'd1);
    chk("rst_addr", 32'(cpu_ins_address[0]), 32'd0);
    chk("rst_ins", 32'(cpu_ins[1]), 32'd0);
    chk("rst_ready", 32'(host_ready[0]), 32'd0);
    chk("rst_busy", 32'(busy[1]), 32'd0);
    chk("rst_rvalid", 32'(result_valid[0]), 32'd0);
    chk("rst_wc", 32'(word_count[0]), 32'd0);
    chk("rst_res_d", 32'(result_d[0]), 32'd0);

    // Six-word program, host_last on the sixth
    do_reset();
    do_start();
    for (int i = 0; i < 6; i++) begin
      send(prog[i][11:4], prog[i][3:0], i == 5, ok);
      chk("t1_accept", 32'(ok), 32'd1);
    end
    chk("t1_rst_hold", 32'(cpu_rst[0]), 32'd1);
    tick();
    chk("t1_rst_fall", 32'(cpu_rst[0]), 32'd0);
    wait_done(60);
    for (int k = 0; k < 6; k++) chk("t1_mem_dut0", 32'(g_dut[0].mem[k]), 32'(prog[k]));
    chk("t1_nopad_dut0", 32'(g_dut[0].mem[6]), 32'hFFF);
    for (int k = 6; k < 16; k++) chk("t1_pad_dut1", 32'(g_dut[1].mem[k]), 32'h0F0);
    chk("t1_wc0", 32'(word_count[0]), 32'd6);
    chk("t1_wc1", 32'(word_count[1]), 32'd6);
    chk("t1_res_d", 32'(result_d[0]), 32'hA);
    chk("t1_res_zf", 32'(result_zf[0]), 32'd1);
    chk("t1_res_cf", 32'(result_cf[1]), 32'd0);
    chk("t1_low0", 32'(g_dut[0].low_cnt), 32'd5);
    chk("t1_low1", 32'(g_dut[1].low_cnt), 32'd5);

    // Three-word program: PAD writes addresses 3..15
    do_reset();
    do_start();
    for (int i = 0; i < 3; i++) send(prog[i][11:4], prog[i][3:0], i == 2, ok);
    for (int a = 3; a < 16; a++) begin
      sb.push_back({4'(a), 8'h0F, 4'h0});
      tick();
      pop_chk("pad", 1'b1);
    end
    chk("t2_rst_hold", 32'(cpu_rst[1]), 32'd1);
    tick();
    chk("t2_rst_fall", 32'(cpu_rst[1]), 32'd0);
    wait_done(60);
    chk("t2_wc0", 32'(word_count[0]), 32'd3);
    chk("t2_wc1", 32'(word_count[1]), 32'd3);
    chk("t2_mem2", 32'(g_dut[1].mem[2]), 32'(prog[2]));
    chk("t2_mem15", 32'(g_dut[1].mem[15]), 32'h0F0);

    // Backpressure: host_valid 1,0,0,1
    do_reset();
    do_start();
    send(8'h1A, 4'h3, 1'b0, ok);
    tick();
    chk("gap_addr", 32'(cpu_ins_address[0]), 32'd0);
    chk("gap_ins", 32'(cpu_ins[0]), 32'h1A);
    tick();
    chk("gap_data", 32'(cpu_d_in[1]), 32'h3);
    chk("gap_wc", 32'(word_count[0]), 32'd1);
    send(8'h1B, 4'h4, 1'b1, ok);
    chk("gap_wc2", 32'(word_count[1]), 32'd2);
    wait_done(60);

    // Overflow: twenty words, no host_last
    do_reset();
    do_start();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      send(8'(8'h20 + i), 4'(i), 1'b0, ok);
      acc += int'(ok);
      if (i == 15) chk("ovf_ready_low", 32'(host_ready[0]), 32'd0);
      if (i == 16) chk("ovf_nopad", 32'(cpu_rst[1]), 32'd0);
    end
    chk("ovf_accepted", 32'(acc), 32'd16);
    chk("ovf_addr0", 32'(cpu_ins_address[0]), 32'd15);
    chk("ovf_addr1", 32'(cpu_ins_address[1]), 32'd15);
    chk("ovf_last_ins", 32'(cpu_ins[1]), 32'h2F);
    wait_done(60);
    chk("ovf_wc", 32'(word_count[0]), 32'd16);
    chk("ovf_mem0", 32'(g_dut[0].mem[0]), 32'h200);
    chk("ovf_mem15", 32'(g_dut[0].mem[15]), 32'h2FF);

    // Restart from DONE, then abort mid-RUN
    do_start();
    chk("restart_rvalid", 32'(result_valid[0]), 32'd0);
    chk("restart_wc", 32'(word_count[0]), 32'd0);
    send(8'h0F, 4'h0, 1'b1, ok);
    tick();
    tick();
    chk("pre_abort_run", 32'(cpu_rst[0]), 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_rvalid", 32'(result_valid[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_cpu_rst", 32'(cpu_rst[0]), 32'd1);
    chk("abort_res_hold", 32'(result_d[0]), 32'hA);
    tick();
    tick();
    chk("abort_stay_idle", 32'(busy[1]), 32'd0);
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_busy", 32'(busy[0]), 32'd0);
    chk("start_abort_ready", 32'(host_ready[0]), 32'd0);

    // Asynchronous reset in the middle of RUN
    do_start();
    for (int i = 0; i < 3; i++) send(prog[i][11:4], prog[i][3:0], i == 2, ok);
    tick();
    tick();
    chk("pre_rst_run", 32'(cpu_rst[0]), 32'd0);
    chk("pre_rst_addr", 32'(cpu_ins_address[0]), 32'd2);
    #3;
    rst = 1'b0;
    #1;
    chk("async_cpu_rst", 32'(cpu_rst[0]), 32'd1);
    chk("async_busy", 32'(busy[0]), 32'd0);
    chk("async_addr", 32'(cpu_ins_address[0]), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("post_rst_busy", 32'(busy[0]), 32'd0);
    chk("post_rst_rvalid", 32'(result_valid[0]), 32'd0);
    chk("post_rst_ready", 32'(host_ready[0]), 32'd0);
    chk("post_rst_res_d", 32'(result_d[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
